sfft_seq_ctrl: RTL and testbench
================================

// Module: sfft_seq_ctrl
// PURPOSE
//  Frame sequencer for the stochastic butterfly FFT array. Runs one transform per iStart:
//  clear, weight load, RUNLEN-cycle bitstream run, pipeline flush, done.
//  Drives the array's iEn/loadW/iClr and gives upstream/downstream handshakes.
//  One instance per FFT array, between the bitstream generators and the array.
// PARAMETERS
//  BITWIDTH  8               bitstream length is RUNLEN = 2**BITWIDTH cycles
//  NUMINPUTS 8               FFT points; must be a power of 2, >= 2
//  LOG2N     $clog2(NUMINPUTS) butterfly stages; pipeline latency = LOG2N cycles (1 per stage)
//  LOADCYC   2               cycles loadW is held high; 1..255
// PORTS
//  iClk        in  1           clock, rising edge
//  iRst        in  1           asynchronous reset, active-high
//  iStart      in  1           start one frame; sampled only in IDLE
//  iStall      in  1           freeze RUN/FLUSH progress this cycle
//  oBusy       out 1           high in every state except IDLE
//  oClr        out 1           to array iClr
//  oLoadW      out 1           to array loadW
//  oEn         out 1           to array iEn
//  oInReady    out 1           upstream must present one input bit per point this cycle
//  oOutValid   out 1           array output bits valid this cycle
//  oDone       out 1           one-cycle pulse at frame end
//  oCnt        out BITWIDTH+1  phase counter (debug)
//  oFrameCnt   out 8           completed frames, wraps 255->0
// BEHAVIOUR
//  Reset: state IDLE; oCnt, oFrameCnt = 0; all 1-bit outputs 0. Outputs are registered
//   Moore decodes of state/counter. Reset mid-frame aborts immediately; no oDone.
//  FSM, one transition per iClk edge:
//   IDLE : iStart=1 -> CLR; else stay. oCnt held at 0.
//   CLR  : 1 cycle, oClr=1 -> LOAD.
//   LOAD : LOADCYC cycles, oLoadW=1 -> RUN. iStall ignored.
//   RUN  : oEn=oInReady=1 for RUNLEN advancing cycles; oCnt counts 0..RUNLEN-1 -> FLUSH.
//   FLUSH: oEn=1, oInReady=0, for LOG2N advancing cycles -> DONE.
//   DONE : 1 cycle, oDone=1, oFrameCnt+1 -> IDLE. iStart here is ignored.
//  oOutValid=1 in RUN when oCnt >= LOG2N, and in all FLUSH cycles:
//   exactly RUNLEN valid cycles per frame.
//  oCnt resets to 0 on entry to LOAD, RUN and FLUSH.
//  iStall=1 in RUN/FLUSH: oEn, oInReady, oOutValid forced 0; oCnt and state frozen.
//   Consecutive stalls extend the frame 1 cycle each.
//  iStart while oBusy=1 is ignored (not queued).
//  If RUNLEN <= LOG2N, oOutValid is asserted in FLUSH only (degenerate; still legal).
// CONFIGURATION
//  SFFT_CTRL_ABORT_EN defined:
//   - adds ports iAbort (in 1) and oAbortAck (out 1).
//   - iAbort=1 in any non-IDLE state: next state IDLE, oAbortAck pulses for 1 cycle.
//   - No oDone; oFrameCnt unchanged; iAbort in IDLE ignored.
//   - iAbort has priority over iStall and over the DONE transition.
//  SFFT_CTRL_ABORT_EN undefined: ports absent; every started frame runs to DONE.
// TESTING (BITWIDTH=4, NUMINPUTS=8, LOADCYC=2; start sampled at edge 0, cycle n = after edge n)
//  1 Nominal frame:
//    - oClr at cycle 1; oLoadW at cycles 2-3; oEn at cycles 4-22.
//    - oInReady at cycles 4-19; oOutValid at cycles 7-22 (16 cycles).
//    - oDone at cycle 23; oBusy low at cycle 24; oFrameCnt=1.
//  2 Stall: iStall high for cycles 10-12 -> oEn/oInReady low in those cycles;
//    oDone at cycle 26; still 16 oOutValid cycles.
//  3 Ignored start: iStart pulsed at cycles 5 and 23 -> no restart;
//    oBusy low at cycle 24, next frame only on a later iStart.
//  4 Async reset: iRst asserted mid-cycle 15 -> all outputs 0 immediately;
//    no oDone; oFrameCnt=0.
//  5 Wrap: 256 back-to-back frames -> oFrameCnt reads 0 after the last oDone.
//  6 (ABORT_EN) iAbort at cycle 12 -> IDLE at cycle 13; oAbortAck=1 at cycle 13;
//    no oDone; oFrameCnt unchanged.

Source files
------------

// File: rtl/sfft_seq_ctrl.sv
// sfft_seq_ctrl: frame sequencer for the stochastic butterfly FFT array.
// One transform per iStart: CLR -> LOAD -> RUN -> FLUSH -> DONE -> IDLE.
// All outputs are registered decodes of the state, the phase counter and iStall.
// Optional feature macro: SFFT_CTRL_ABORT_EN (adds iAbort / oAbortAck).
module sfft_seq_ctrl #(
  parameter int BITWIDTH  = 8,
  parameter int NUMINPUTS = 8,
  parameter int LOADCYC   = 2
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iStart,
  input  logic                iStall,
  output logic                oBusy,
  output logic                oClr,
  output logic                oLoadW,
  output logic                oEn,
  output logic                oInReady,
  output logic                oOutValid,
  output logic                oDone,
  output logic [BITWIDTH:0]   oCnt,
  output logic [7:0]          oFrameCnt
`ifdef SFFT_CTRL_ABORT_EN
  ,
  input  logic                iAbort,
  output logic                oAbortAck
`endif
);

  localparam int LOG2N  = $clog2(NUMINPUTS);
  localparam int RUNLEN = 2 ** BITWIDTH;
  // The phase counter must also cover LOAD (up to 255 cycles), so never narrower than 8 bits.
  localparam int CW     = ((BITWIDTH + 1) > 8) ? (BITWIDTH + 1) : 8;

  localparam logic [CW-1:0] LOAD_LAST  = CW'(LOADCYC - 1);
  localparam logic [CW-1:0] RUN_LAST   = CW'(RUNLEN - 1);
  localparam logic [CW-1:0] FLUSH_LAST = CW'(LOG2N - 1);
  localparam logic [CW-1:0] VALID_MIN  = CW'(LOG2N);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_LOAD  = 3'd2,
    S_RUN   = 3'd3,
    S_FLUSH = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              abort_s;

  logic              busy_q, busy_d;
  logic              clr_q, clr_d;
  logic              loadw_q, loadw_d;
  logic              en_q, en_d;
  logic              rdy_q, rdy_d;
  logic              val_q, val_d;
  logic              done_q, done_d;
  logic [BITWIDTH:0] ocnt_q, ocnt_d;
  logic [7:0]        frame_q, frame_d;
`ifdef SFFT_CTRL_ABORT_EN
  logic              ack_q, ack_d;
`endif

  // Abort request qualifier: only meaningful while a frame is in progress.
  always_comb begin
`ifdef SFFT_CTRL_ABORT_EN
    abort_s = iAbort & (state_q != S_IDLE);
`else
    abort_s = 1'b0;
`endif
  end

  // State and phase-counter registers.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter logic; stall freezes RUN/FLUSH, abort overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (iStart) begin
          state_d = S_CLR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLR: begin
        state_d = S_LOAD;
        cnt_d   = '0;
      end
      S_LOAD: begin
        if (cnt_q == LOAD_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      S_RUN: begin
        if (iStall) begin
          cnt_d = cnt_q;
        end else if (cnt_q == RUN_LAST) begin
          state_d = S_FLUSH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      S_FLUSH: begin
        if (iStall) begin
          cnt_d = cnt_q;
        end else if (cnt_q == FLUSH_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (abort_s) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      state_d = state_d;
    end
  end

  // Output decode of the current state; a stalled cycle drives no enable or valid.
  always_comb begin
    busy_d  = 1'b0;
    clr_d   = 1'b0;
    loadw_d = 1'b0;
    en_d    = 1'b0;
    rdy_d   = 1'b0;
    val_d   = 1'b0;
    done_d  = 1'b0;
    ocnt_d  = cnt_q[BITWIDTH:0];
    frame_d = frame_q;
`ifdef SFFT_CTRL_ABORT_EN
    ack_d   = abort_s;
`endif
    if (abort_s) begin
      ocnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          busy_d = 1'b0;
        end
        S_CLR: begin
          busy_d = 1'b1;
          clr_d  = 1'b1;
        end
        S_LOAD: begin
          busy_d  = 1'b1;
          loadw_d = 1'b1;
        end
        S_RUN: begin
          busy_d = 1'b1;
          en_d   = ~iStall;
          rdy_d  = ~iStall;
          val_d  = ~iStall & (cnt_q >= VALID_MIN);
        end
        S_FLUSH: begin
          busy_d = 1'b1;
          en_d   = ~iStall;
          val_d  = ~iStall;
        end
        S_DONE: begin
          busy_d  = 1'b1;
          done_d  = 1'b1;
          frame_d = frame_q + 8'd1;
        end
        default: begin
          busy_d = 1'b0;
        end
      endcase
    end
  end

  // Registered outputs.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      busy_q  <= 1'b0;
      clr_q   <= 1'b0;
      loadw_q <= 1'b0;
      en_q    <= 1'b0;
      rdy_q   <= 1'b0;
      val_q   <= 1'b0;
      done_q  <= 1'b0;
      ocnt_q  <= '0;
      frame_q <= 8'd0;
`ifdef SFFT_CTRL_ABORT_EN
      ack_q   <= 1'b0;
`endif
    end else begin
      busy_q  <= busy_d;
      clr_q   <= clr_d;
      loadw_q <= loadw_d;
      en_q    <= en_d;
      rdy_q   <= rdy_d;
      val_q   <= val_d;
      done_q  <= done_d;
      ocnt_q  <= ocnt_d;
      frame_q <= frame_d;
`ifdef SFFT_CTRL_ABORT_EN
      ack_q   <= ack_d;
`endif
    end
  end

  assign oBusy     = busy_q;
  assign oClr      = clr_q;
  assign oLoadW    = loadw_q;
  assign oEn       = en_q;
  assign oInReady  = rdy_q;
  assign oOutValid = val_q;
  assign oDone     = done_q;
  assign oCnt      = ocnt_q;
  assign oFrameCnt = frame_q;
`ifdef SFFT_CTRL_ABORT_EN
  assign oAbortAck = ack_q;
`endif

endmodule

// File: tb/tb_sfft_seq_ctrl.sv
// Scoreboard bench for sfft_seq_ctrl (BITWIDTH=4, NUMINPUTS=8, LOADCYC=2).
// Stimulus pushes the expected per-frame profile; a negedge monitor collects the
// observed profile from the oClr pulse to oDone and compares on each oDone.
module tb_sfft_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stall = 1'b0;
  logic       busy, clr, loadw, en, rdy, val, done;
  logic [4:0] cnt;
  logic [7:0] fcnt;
`ifdef SFFT_CTRL_ABORT_EN
  logic       abort = 1'b0;
  logic       ack;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    int first_lw; int lw_n; int first_en; int last_en; int en_n; int rdy_n;
    int last_rdy; int max_cnt; int val_n; int first_val; int done; int frame;
  } prof_t;

  prof_t sb[$];

  sfft_seq_ctrl #(.BITWIDTH(4), .NUMINPUTS(8), .LOADCYC(2)) dut (
    .iClk(clk), .iRst(rst), .iStart(start), .iStall(stall),
    .oBusy(busy), .oClr(clr), .oLoadW(loadw), .oEn(en), .oInReady(rdy),
    .oOutValid(val), .oDone(done), .oCnt(cnt), .oFrameCnt(fcnt)
`ifdef SFFT_CTRL_ABORT_EN
    , .iAbort(abort), .oAbortAck(ack)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  // Hand-derived profile: start sampled at edge 0, s stalled cycles inside RUN.
  function automatic prof_t nominal(input int frame, input int s);
    prof_t p;
    p.first_lw = 2;  p.lw_n = 2;  p.first_en = 4;  p.last_en = 22 + s;
    p.en_n = 19;     p.rdy_n = 16; p.last_rdy = 19 + s; p.max_cnt = 15;
    p.val_n = 16;    p.first_val = 7; p.done = 23 + s; p.frame = frame;
    return p;
  endfunction

  // Monitor: build the observed profile and score it on every oDone.
  prof_t g;
  bit    active = 0;
  bit    chk_idle = 0;
  int    cyc = 0;
  always @(negedge clk) begin
    if (rst) begin
      active   = 0;
      chk_idle = 0;
    end else begin
      if (chk_idle) begin
        chk("busy_after_done", int'(busy), 0);
        chk_idle = 0;
      end
      if (clr && !active) begin
        active = 1;
        cyc = 1;
        g = '{default: 0};
      end else if (active) begin
        cyc++;
      end
`ifdef SFFT_CTRL_ABORT_EN
      if (ack) active = 0;
`endif
      if (active) begin
        if (loadw) begin g.lw_n++; if (g.first_lw == 0) g.first_lw = cyc; end
        if (en) begin g.en_n++; g.last_en = cyc; if (g.first_en == 0) g.first_en = cyc; end
        if (rdy) begin
          g.rdy_n++; g.last_rdy = cyc;
          if (int'(cnt) > g.max_cnt) g.max_cnt = int'(cnt);
        end
        if (val) begin g.val_n++; if (g.first_val == 0) g.first_val = cyc; end
        if (done) begin
          prof_t e;
          g.done = cyc;
          g.frame = int'(fcnt);
          if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("first_loadw", g.first_lw, e.first_lw);
            chk("loadw_cycles", g.lw_n, e.lw_n);
            chk("first_en", g.first_en, e.first_en);
            chk("last_en", g.last_en, e.last_en);
            chk("en_cycles", g.en_n, e.en_n);
            chk("inready_cycles", g.rdy_n, e.rdy_n);
            chk("last_inready", g.last_rdy, e.last_rdy);
            chk("max_run_cnt", g.max_cnt, e.max_cnt);
            chk("outvalid_cycles", g.val_n, e.val_n);
            chk("first_outvalid", g.first_val, e.first_val);
            chk("done_cycle", g.done, e.done);
            chk("frame_cnt", g.frame, e.frame);
          end
          active = 0;
          chk_idle = 1;
        end
      end
    end
  end

  // Pulse iStart so that it is sampled at the next rising edge ("edge 0").
  task automatic kick();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Bounded wait until the scoreboard has drained.
  task automatic drain(input string nm, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk({nm, "_timeout"}, sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame", int'(fcnt), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", int'(busy), 0);
    chk("idle_cnt", int'(cnt), 0);
    chk("idle_en", int'(en), 0);

    // 1: nominal frame
    sb.push_back(nominal(1, 0));
    @(posedge clk); #1;
    kick();
    drain("nominal", 60);

    // 2: stall sampled at edges 10..12
    sb.push_back(nominal(2, 3));
    @(posedge clk); #1;
    kick();
    repeat (9) @(posedge clk);
    #1 stall = 1'b1;
    repeat (3) @(posedge clk);
    #1 stall = 1'b0;
    drain("stall", 60);

    // 3: iStart while busy (edge 5) and in DONE (edge 23) is ignored
    sb.push_back(nominal(3, 0));
    @(posedge clk); #1;
    kick();
    repeat (4) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (17) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    drain("ignored_start", 60);
    repeat (5) @(negedge clk);
    chk("no_restart_busy", int'(busy), 0);
    chk("no_restart_frame", int'(fcnt), 3);

    // 4: async reset in the middle of cycle 15
    @(posedge clk); #1;
    kick();
    repeat (15) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_en", int'({clr, loadw, en, rdy, val, done}), 0);
    chk("arst_cnt", int'(cnt), 0);
    chk("arst_frame", int'(fcnt), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("arst_no_done_frame", int'(fcnt), 0);
    chk("arst_idle", int'(busy), 0);

    // 5: 256 back-to-back frames wrap the frame counter to 0
    @(posedge clk); #1;
    for (int i = 0; i < 256; i++) begin
      int n;
      sb.push_back(nominal((i + 1) % 256, 0));
      kick();
      n = 0;
      while (!done && n < 60) begin
        @(negedge clk);
        n++;
      end
      if (!done) begin
        chk("wrap_done_timeout", i, -1);
        break;
      end
    end
    drain("wrap", 60);
    chk("wrap_frame", int'(fcnt), 0);

`ifdef SFFT_CTRL_ABORT_EN
    // 6: abort present during cycle 12 -> acknowledged and idle at cycle 13
    @(posedge clk); #1;
    kick();
    repeat (12) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("abort_ack", int'(ack), 1);
    chk("abort_busy", int'(busy), 0);
    repeat (30) @(negedge clk);
    chk("abort_frame", int'(fcnt), 0);
    chk("abort_no_done", int'(sb.size()), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
